// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio averaging filter.
//   DATA_W_DEF - default signed sample width per channel
//   sample_t   - signed sample at the default width
//   state_t    - sequencing FSM states
//   LFSR_SEED / LFSR_TAPS / lfsr_next - noise generator constants and step,
//              only referenced when NOISE_INJECT_EN is defined
package audio_pkg;

  localparam int DATA_W_DEF = 24;

  typedef logic signed [DATA_W_DEF-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shift form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/audio_avg_filter_if.sv
// audio_avg_filter_if: codec-side read/write handshake bundle.
//   read_ready, readdata_left/right : codec offers a sample pair
//   read                            : filter consumes the pair (1-cycle pulse)
//   write_ready                     : codec can accept a pair
//   writedata_left/right, write     : filter delivers a pair (1-cycle pulse)
// Modports: slave = filter side, master = codec/testbench side.
interface audio_avg_filter_if
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic                     read_ready;
  logic                     read;
  logic signed [DATA_W-1:0] readdata_left;
  logic signed [DATA_W-1:0] readdata_right;
  logic                     write_ready;
  logic                     write;
  logic signed [DATA_W-1:0] writedata_left;
  logic signed [DATA_W-1:0] writedata_right;

  modport slave (
    input  read_ready, readdata_left, readdata_right, write_ready,
    output read, writedata_left, writedata_right, write
  );

  modport master (
    output read_ready, readdata_left, readdata_right, write_ready,
    input  read, writedata_left, writedata_right, write
  );

endinterface

// File: rtl/audio_avg_filter_avg_channel.sv
// avg_channel: one channel of the moving-average filter.
//   clk_i, rst_n_i : clock, async active-low reset (clears history, sum, ptr)
//   en_i           : commit sample_i into the window this cycle
//   sample_i       : new sample
//   avg_o          : floor(new_sum / N), combinational, valid while en_i
module avg_channel #(
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] avg_o
);

  localparam int N  = 1 << DEPTH_LOG2;
  localparam int SW = DATA_W + DEPTH_LOG2;

  logic signed [DATA_W-1:0] hist_q [N];
  logic [DEPTH_LOG2-1:0]    ptr_q;
  logic signed [SW-1:0]     sum_q;
  logic signed [SW-1:0]     sum_d;

  // Oldest sample leaves the window as the new one enters.
  always_comb begin
    sum_d = sum_q + SW'(sample_i) - SW'(hist_q[ptr_q]);
  end

  // Dropping the low bits of a two's-complement sum is a floor division.
  assign avg_o = sum_d[SW-1:DEPTH_LOG2];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sum_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < N; i++) hist_q[i] <= '0;
    end else if (en_i) begin
      sum_q         <= sum_d;
      hist_q[ptr_q] <= sample_i;
      ptr_q         <= ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/audio_avg_filter.sv
// audio_avg_filter: N-sample moving-average filter between codec read and
// write handshakes, N = 2**DEPTH_LOG2 (DEPTH_LOG2 legal range 1..6).
//   CLOCK_50 : clock
//   resetn   : async active-low reset
//   bypass   : 1 = output the captured sample unfiltered (history still updates)
//   bus      : codec handshake (audio_avg_filter_if.slave)
// Optional macro NOISE_INJECT_EN: adds LFSR noise to each captured sample
// (saturating, requires DATA_W >= 14). Undefined: samples used unchanged.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | wait for read_ready; capture pair and pulse read
// ST_CALC | update both channels' window, load writedata
// ST_OUT  | hold writedata until write_ready, pulse write
module audio_avg_filter
  import audio_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                bypass,
  audio_avg_filter_if.slave   bus
);

  state_t                   state_q, state_d;
  logic                     capture, calc, read_d, write_d;
  logic signed [DATA_W-1:0] in_l, in_r;
  logic signed [DATA_W-1:0] smp_l_q, smp_r_q;
  logic signed [DATA_W-1:0] avg_l, avg_r;
  logic signed [DATA_W-1:0] wd_l_q, wd_r_q;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    calc    = 1'b0;
    read_d  = 1'b0;
    write_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // resetn gate keeps read low while reset is asserted
        if (bus.read_ready && resetn) begin
          capture = 1'b1;
          read_d  = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        calc    = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.write_ready) begin
          write_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      smp_l_q <= '0;
      smp_r_q <= '0;
      wd_l_q  <= '0;
      wd_r_q  <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        smp_l_q <= in_l;
        smp_r_q <= in_r;
      end
      if (calc) begin
        wd_l_q <= bypass ? smp_l_q : avg_l;
        wd_r_q <= bypass ? smp_r_q : avg_r;
      end
    end
  end

`ifdef NOISE_INJECT_EN
  logic [15:0]   lfsr_q;
  logic [DATA_W:0] noise;

  // 3-bit signed LFSR slice scaled by 2**11, one bit of headroom for the add
  assign noise = {{(DATA_W-13){lfsr_q[2]}}, lfsr_q[2:0], 11'd0};

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W:0]   n);
    logic [DATA_W:0] s;
    s = {x[DATA_W-1], x} + n;
    if (s[DATA_W] != s[DATA_W-1])
      return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    return s[DATA_W-1:0];
  endfunction

  assign in_l = sat_add(bus.readdata_left, noise);
  assign in_r = sat_add(bus.readdata_right, noise);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) lfsr_q <= LFSR_SEED;
    else if (capture) lfsr_q <= lfsr_next(lfsr_q);
  end
`else
  assign in_l = bus.readdata_left;
  assign in_r = bus.readdata_right;
`endif

  avg_channel #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_left (
    .clk_i    (CLOCK_50),
    .rst_n_i  (resetn),
    .en_i     (calc),
    .sample_i (smp_l_q),
    .avg_o    (avg_l)
  );

  avg_channel #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_right (
    .clk_i    (CLOCK_50),
    .rst_n_i  (resetn),
    .en_i     (calc),
    .sample_i (smp_r_q),
    .avg_o    (avg_r)
  );

  assign bus.read            = read_d;
  assign bus.write           = write_d;
  assign bus.writedata_left  = wd_l_q;
  assign bus.writedata_right = wd_r_q;

endmodule

// File: tb/tb_audio_avg_filter.sv
// tb_audio_avg_filter: randomized self-checking bench for audio_avg_filter
// (DATA_W=24, N=8) against a window-sum reference model. Honors
// NOISE_INJECT_EN by modelling the noise LFSR in the reference.
module tb_audio_avg_filter;
  import audio_pkg::*;

`ifdef NOISE_INJECT_EN
  localparam int NOISE_GAIN = 1;
`else
  localparam int NOISE_GAIN = 0;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic bypass = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always #10 clk = ~clk;

  audio_avg_filter_if #(.DATA_W(24)) bus ();

  audio_avg_filter #(.DATA_W(24), .DEPTH_LOG2(3)) dut (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .bypass   (bypass),
    .bus      (bus)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // reference: last 8 captured samples per channel, plain sum / floor division
  int          hist_l [8];
  int          hist_r [8];
  int          hp;
  logic [15:0] lfsr_m;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      hist_l[i] = 0;
      hist_r[i] = 0;
    end
    hp     = 0;
    lfsr_m = 16'hACE1;
  endtask

  function automatic int floor8(input int s);
    int q;
    q = s / 8;
    if (s < 0 && (s % 8) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int noisy(input int x, input logic [15:0] lf);
    logic signed [2:0] n3;
    int v;
    n3 = lf[2:0];
    v  = x + NOISE_GAIN * int'(n3) * 2048;
    if (v > 8388607)  v = 8388607;
    if (v < -8388608) v = -8388608;
    return v;
  endfunction

  task automatic model_step(input int l, input int r, input bit byp,
                            output int el, output int er);
    int cl, cr, sl, sr;
    cl = noisy(l, lfsr_m);
    cr = noisy(r, lfsr_m);
    lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    hist_l[hp] = cl;
    hist_r[hp] = cr;
    hp = (hp + 1) % 8;
    sl = 0;
    sr = 0;
    for (int i = 0; i < 8; i++) begin
      sl += hist_l[i];
      sr += hist_r[i];
    end
    el = byp ? cl : floor8(sl);
    er = byp ? cr : floor8(sr);
  endtask

  task automatic wait_read(input string tag);
    int n;
    n = 0;
    while (!bus.read && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_read"}, bus.read, 1);
  endtask

  task automatic do_sample(input logic signed [23:0] l, input logic signed [23:0] r,
                           input bit byp, input int wr_delay, input string tag,
                           output int got_l, output int got_r);
    int el, er, cyc, lat_exp;
    got_l = 0;
    got_r = 0;
    @(negedge clk);
    bus.readdata_left  = l;
    bus.readdata_right = r;
    bypass             = byp;
    bus.write_ready    = (wr_delay == 0);
    bus.read_ready     = 1'b1;
    #1;
    wait_read(tag);
    model_step(l, r, byp, el, er);
    @(negedge clk);
    bus.read_ready = 1'b0;
    cyc = 1;
    while (cyc < 30) begin
      if (cyc >= 1 + wr_delay) bus.write_ready = 1'b1;
      #1;
      if (bus.write) break;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_write"}, bus.write, 1);
    if (bus.write) begin
      got_l   = int'(bus.writedata_left);
      got_r   = int'(bus.writedata_right);
      lat_exp = (1 + wr_delay > 2) ? 1 + wr_delay : 2;
      chk({tag, "_rw_excl"}, bus.read, 0);
      chk({tag, "_left"}, got_l, el);
      chk({tag, "_right"}, got_r, er);
      chk({tag, "_latency"}, cyc, lat_exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    bus.read_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int gl, gr, el, er, reads, writes;
    bus.read_ready      = 1'b0;
    bus.write_ready     = 1'b0;
    bus.readdata_left   = '0;
    bus.readdata_right  = '0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_read", bus.read, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_wd_l", bus.writedata_left, 0);
    chk("rst_wd_r", bus.writedata_right, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // constant 800 ramps 100..700 then holds 800
    for (int i = 0; i < 10; i++) begin
      do_sample(24'sd800, 24'sd800, 1'b0, 0, "const800", gl, gr);
`ifndef NOISE_INJECT_EN
      chk("const800_lit", gl, (i < 7) ? 100 * (i + 1) : 800);
`endif
    end

    // single -8 then zeros: floor gives -1 until it leaves the window
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      do_sample((i == 0) ? -24'sd8 : 24'sd0, 24'sd0, 1'b0, 0, "impulse", gl, gr);
`ifndef NOISE_INJECT_EN
      chk("impulse_lit", gl, (i < 8) ? -1 : 0);
`endif
    end

    // bypass passes full-scale extremes exactly
    do_sample(24'sh7FFFFF, 24'sh800000, 1'b1, 0, "bypass_a", gl, gr);
`ifndef NOISE_INJECT_EN
    chk("bypass_a_lit_l", gl, 8388607);
    chk("bypass_a_lit_r", gr, -8388608);
`endif
    do_sample(24'sh800000, 24'sh7FFFFF, 1'b1, 0, "bypass_b", gl, gr);
    do_sample(24'sd1234, -24'sd4321, 1'b0, 0, "unbypass", gl, gr);

    // write_ready stalled with read_ready held high
    @(negedge clk);
    bus.readdata_left  = 24'sd1000;
    bus.readdata_right = -24'sd1000;
    bypass             = 1'b0;
    bus.write_ready    = 1'b0;
    bus.read_ready     = 1'b1;
    #1;
    wait_read("stall");
    model_step(1000, -1000, 1'b0, el, er);
    reads = 0;
    @(negedge clk); #1;
    reads += int'(bus.read);
    @(negedge clk); #1;
    reads += int'(bus.read);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold_l", bus.writedata_left, el);
      chk("stall_hold_r", bus.writedata_right, er);
      chk("stall_no_write", bus.write, 0);
      @(negedge clk); #1;
      reads += int'(bus.read);
    end
    chk("stall_no_read", reads, 0);
    bus.write_ready = 1'b1;
    bus.read_ready  = 1'b0;
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      writes += int'(bus.write);
      @(negedge clk);
    end
    chk("stall_one_write", writes, 1);

    // reset while in OUT drops the in-flight sample
    bus.readdata_left  = 24'sd500;
    bus.readdata_right = 24'sd500;
    bus.write_ready    = 1'b0;
    bus.read_ready     = 1'b1;
    #1;
    wait_read("midrst");
    @(negedge clk);
    bus.read_ready = 1'b0;
    @(negedge clk);
    rst_n           = 1'b0;
    bus.write_ready = 1'b1;
    #1;
    chk("midrst_write", bus.write, 0);
    chk("midrst_read", bus.read, 0);
    chk("midrst_wd_l", bus.writedata_left, 0);
    chk("midrst_wd_r", bus.writedata_right, 0);
    writes = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      #1;
      writes += int'(bus.write);
    end
    chk("midrst_no_write", writes, 0);
    model_reset();
    do_sample(24'sd800, 24'sd800, 1'b0, 0, "post_rst", gl, gr);
`ifndef NOISE_INJECT_EN
    chk("post_rst_lit", gl, 100);
`endif

    // bypass with zero input exposes the noise sequence (zero without noise)
    apply_reset();
    for (int i = 0; i < 16; i++)
      do_sample(24'sd0, 24'sd0, 1'b1, 0, "noise", gl, gr);

    // randomized samples, bypass and write_ready back-pressure
    for (int i = 0; i < 40; i++) begin
      logic signed [23:0] rl, rr;
      rl = 24'($urandom);
      rr = 24'($urandom);
      do_sample(rl, rr, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                "rand", gl, gr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
